// File: rtl/rv_isa_pkg.sv
// RISC-V opcode classes, encoder error codes and immediate limits, shared by the
// immediate generator and the instruction encoder.
package rv_isa_pkg;

  localparam int unsigned OPC_WIDTH = 5;

  localparam logic [OPC_WIDTH-1:0] OPC_LOAD   = 5'b00000;
  localparam logic [OPC_WIDTH-1:0] OPC_OP_IMM = 5'b00100;
  localparam logic [OPC_WIDTH-1:0] OPC_AUIPC  = 5'b00101;
  localparam logic [OPC_WIDTH-1:0] OPC_STORE  = 5'b01000;
  localparam logic [OPC_WIDTH-1:0] OPC_OP     = 5'b01100;
  localparam logic [OPC_WIDTH-1:0] OPC_LUI    = 5'b01101;
  localparam logic [OPC_WIDTH-1:0] OPC_BRANCH = 5'b11000;
  localparam logic [OPC_WIDTH-1:0] OPC_JAL    = 5'b11011;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_RANGE    = 2'b01,
    ERR_MISALIGN = 2'b10,
    ERR_UNSUP    = 2'b11
  } err_code_e;

  localparam int IMM_IS_MIN = -2048;
  localparam int IMM_IS_MAX = 2047;
  localparam int IMM_B_MIN  = -4096;
  localparam int IMM_B_MAX  = 4094;
  localparam int IMM_J_MIN  = -(1 << 20);
  localparam int IMM_J_MAX  = (1 << 20) - 2;

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input, instruction-memory write port and status of instr_encoder.
// master = bundle source / memory side, slave = the encoder.
interface instr_encoder_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  start;
  logic                  in_valid;
  logic                  in_ready;
  logic [4:0]            in_opcode;
  logic [4:0]            in_rd;
  logic [4:0]            in_rs1;
  logic [4:0]            in_rs2;
  logic [2:0]            in_funct3;
  logic [6:0]            in_funct7;
  logic [31:0]           in_imm;
  logic                  wr_en;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic                  err_valid;
  logic [1:0]            err_code;
  logic                  full;

  modport master (
    output start, in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
           wr_ready,
    input  in_ready, wr_en, wr_addr, wr_data, err_valid, err_code, full
  );

  modport slave (
    input  start, in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
           wr_ready,
    output in_ready, wr_en, wr_addr, wr_data, err_valid, err_code, full
  );
endinterface

// File: rtl/instr_field_packer.sv
// Combinational scatter of decoded fields into a 32-bit RISC-V word plus reject code.
// INSTR_ENCODER_RANGE_CHECK_EN enables range/alignment rejection; otherwise imm is truncated.
module instr_field_packer
  import rv_isa_pkg::*;
(
  input  logic [4:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word_c,
  output err_code_e   err_c
);

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  logic signed [31:0] simm;
  assign simm = signed'(imm);
`endif

  // Misaligned outranks range inside each format; unsupported is handled by default.
  always_comb begin
    word_c = '0;
    err_c  = ERR_NONE;
    unique case (opcode)
      OPC_OP_IMM, OPC_LOAD: begin
        word_c = {imm[11:0], rs1, funct3, rd, opcode, 2'b11};
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        if (simm < IMM_IS_MIN || simm > IMM_IS_MAX) err_c = ERR_RANGE;
`endif
      end
      OPC_STORE: begin
        word_c = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode, 2'b11};
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        if (simm < IMM_IS_MIN || simm > IMM_IS_MAX) err_c = ERR_RANGE;
`endif
      end
      OPC_BRANCH: begin
        word_c = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode, 2'b11};
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        if (imm[0])                                   err_c = ERR_MISALIGN;
        else if (simm < IMM_B_MIN || simm > IMM_B_MAX) err_c = ERR_RANGE;
`endif
      end
      OPC_JAL: begin
        word_c = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode, 2'b11};
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        if (imm[0])                                   err_c = ERR_MISALIGN;
        else if (simm < IMM_J_MIN || simm > IMM_J_MAX) err_c = ERR_RANGE;
`endif
      end
      OPC_AUIPC, OPC_LUI: begin
        word_c = {imm[31:12], rd, opcode, 2'b11};
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        if (imm[11:0] != 12'h000) err_c = ERR_MISALIGN;
`endif
      end
      OPC_OP: begin
        word_c = {funct7, rs2, rs1, funct3, rd, opcode, 2'b11};
      end
      default: begin
        err_c = ERR_UNSUP;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Sequential instruction encoder / program loader: packs field bundles into words and
// writes them at an auto-incrementing address. Optional checks: INSTR_ENCODER_RANGE_CHECK_EN.
module instr_encoder
  import rv_isa_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0
)
(
  input  logic            clk,
  input  logic            rst_n,
  instr_encoder_if.slave  bus
);

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           data_q;
  logic                  err_valid_q;
  err_code_e             err_code_q;
  logic                  full_q;

  logic                  in_ready_c;
  logic                  accept_c;
  logic                  fire_c;
  logic [31:0]           pack_word_c;
  err_code_e             pack_err_c;

  instr_field_packer u_packer (
    .opcode (bus.in_opcode),
    .rd     (bus.in_rd),
    .rs1    (bus.in_rs1),
    .rs2    (bus.in_rs2),
    .funct3 (bus.in_funct3),
    .funct7 (bus.in_funct7),
    .imm    (bus.in_imm),
    .word_c (pack_word_c),
    .err_c  (pack_err_c)
  );

  // A new bundle may enter whenever the single output slot is empty or draining.
  assign in_ready_c = !full_q && !bus.start && (!wr_en_q || bus.wr_ready);
  assign accept_c   = bus.in_valid && in_ready_c;
  assign fire_c     = wr_en_q && bus.wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q     <= 1'b0;
      addr_q      <= BASE;
      data_q      <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      full_q      <= 1'b0;
    end else begin
      err_valid_q <= 1'b0;
      if (bus.start) begin
        wr_en_q <= 1'b0;
        addr_q  <= BASE;
        full_q  <= 1'b0;
      end else begin
        if (fire_c) begin
          addr_q <= addr_q + ADDR_WIDTH'(1);
          if (addr_q == LAST) full_q <= 1'b1;
        end
        // Rejected bundles are consumed without touching the write slot.
        if (accept_c) begin
          if (pack_err_c != ERR_NONE) begin
            wr_en_q     <= 1'b0;
            err_valid_q <= 1'b1;
            err_code_q  <= pack_err_c;
          end else begin
            wr_en_q <= 1'b1;
            data_q  <= pack_word_c;
          end
        end else if (fire_c) begin
          wr_en_q <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = addr_q;
  assign bus.wr_data   = data_q;
  assign bus.err_valid = err_valid_q;
  assign bus.err_code  = 2'(err_code_q);
  assign bus.full      = full_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed spot values plus randomized traffic
// compared every cycle against a behavioural model of the encoder.
module tb_instr_encoder;

  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_WIDTH(AW)) bus ();

  instr_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [4:0] ops_sup [8] = '{5'b00100, 5'b00000, 5'b01000, 5'b11000,
                              5'b11011, 5'b00101, 5'b01101, 5'b01100};
  int bnd [12] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096,
                   -1048576, 1048574, 1048576, -1048578};

  // Expected visible state of the encoder
  logic          m_wr_en, m_err_valid, m_full, m_legal;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_data, m_imm;
  logic [1:0]    m_err_code;
  int            m_fmt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // 1=I 2=S 3=B 4=J 5=U 6=R 0=unsupported
  function automatic int fmt_of(input logic [4:0] op);
    case (op)
      5'b00100, 5'b00000: return 1;
      5'b01000:           return 2;
      5'b11000:           return 3;
      5'b11011:           return 4;
      5'b00101, 5'b01101: return 5;
      5'b01100:           return 6;
      default:            return 0;
    endcase
  endfunction

  // 0 representable, 1 out of range, 2 misaligned
  function automatic int imm_check(input int f, input logic [31:0] imm);
    int v;
    v = imm;
    case (f)
      1, 2: return (v < -2048 || v > 2047) ? 1 : 0;
      3: begin
        if (imm[0]) return 2;
        return (v < -4096 || v > 4094) ? 1 : 0;
      end
      4: begin
        if (imm[0]) return 2;
        return (v < -(1 << 20) || v > (1 << 20) - 2) ? 1 : 0;
      end
      5: return (imm[11:0] != 12'h000) ? 2 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic ref_encode(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [31:0] imm, output logic [31:0] w, output logic [1:0] code);
    int f;
    logic [31:0] lo, regs;
    f    = fmt_of(op);
    lo   = (32'(op) << 2) | 32'h3;
    regs = (32'(rs1) << 15) | (32'(f3) << 12);
    w    = 32'h0;
    case (f)
      1: w = ((imm & 32'hFFF) << 20) | regs | (32'(rd) << 7) | lo;
      2: w = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | regs | ((imm & 32'h1F) << 7) | lo;
      3: w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20)
             | regs | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | lo;
      4: w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
             | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (32'(rd) << 7) | lo;
      5: w = (imm & 32'hFFFFF000) | (32'(rd) << 7) | lo;
      6: w = (32'(f7) << 25) | (32'(rs2) << 20) | regs | (32'(rd) << 7) | lo;
      default: w = 32'h0;
    endcase
    if (f == 0) code = 2'b11;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    else code = 2'(imm_check(f, imm));
`else
    else code = 2'b00;
`endif
  endtask

  // Independent decoder: a legal immediate must survive encode/decode unchanged
  function automatic logic [31:0] decode_imm(input int f, input logic [31:0] w);
    case (f)
      1: return {{20{w[31]}}, w[31:20]};
      2: return {{20{w[31]}}, w[31:25], w[11:7]};
      3: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      4: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      5: return {w[31:12], 12'h000};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_wr_en = 1'b0; m_err_valid = 1'b0; m_full = 1'b0; m_legal = 1'b0;
    m_addr = '0; m_data = '0; m_imm = '0; m_err_code = 2'b00; m_fmt = 0;
  endtask

  // Compare on the falling edge, then advance the model with the inputs the next edge sees
  always @(negedge clk) begin
    logic exp_ready, fire, acc;
    logic [31:0] w;
    logic [1:0]  code;
    if (!rst_n) model_reset();
    exp_ready = !m_full && !bus.start && (!m_wr_en || bus.wr_ready);
    chk("in_ready",  32'(bus.in_ready),  32'(exp_ready));
    chk("wr_en",     32'(bus.wr_en),     32'(m_wr_en));
    chk("wr_addr",   32'(bus.wr_addr),   32'(m_addr));
    chk("wr_data",   bus.wr_data,        m_data);
    chk("err_valid", 32'(bus.err_valid), 32'(m_err_valid));
    chk("err_code",  32'(bus.err_code),  32'(m_err_code));
    chk("full",      32'(bus.full),      32'(m_full));
    if (m_wr_en && m_legal) chk("roundtrip_imm", decode_imm(m_fmt, bus.wr_data), m_imm);
    if (rst_n) begin
      fire = m_wr_en && bus.wr_ready;
      acc  = bus.in_valid && exp_ready;
      m_err_valid = 1'b0;
      if (bus.start) begin
        m_wr_en = 1'b0;
        m_addr  = '0;
        m_full  = 1'b0;
      end else begin
        if (fire) begin
          if (int'(m_addr) == DEPTH - 1) m_full = 1'b1;
          m_addr  = AW'((int'(m_addr) + 1) % DEPTH);
          m_wr_en = 1'b0;
        end
        if (acc) begin
          ref_encode(bus.in_opcode, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_funct3,
                     bus.in_funct7, bus.in_imm, w, code);
          if (code != 2'b00) begin
            m_err_valid = 1'b1;
            m_err_code  = code;
          end else begin
            m_wr_en = 1'b1;
            m_data  = w;
            m_imm   = bus.in_imm;
            m_fmt   = fmt_of(bus.in_opcode);
            m_legal = (m_fmt >= 1 && m_fmt <= 5) && (imm_check(m_fmt, bus.in_imm) == 0);
          end
        end
      end
    end
  end

  task automatic set_fields(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
    bus.in_opcode = op; bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
    bus.in_funct3 = f3; bus.in_funct7 = 7'h00; bus.in_imm = imm;
  endtask

  task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
    set_fields(op, rd, rs1, rs2, f3, imm);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_imm();
    int k;
    k = $urandom_range(0, 5);
    case (k)
      0: return 32'($urandom_range(0, 63)) - 32'd32;
      1: return 32'(bnd[$urandom_range(0, 11)]);
      2: return (32'($urandom_range(0, 10000)) - 32'd5000) & ~32'h1;
      3: return {20'($urandom), 12'h000};
      4: return 32'($urandom);
      default: return (32'($urandom_range(0, 32'h3FFFFF)) - 32'h200000) & ~32'h1;
    endcase
  endfunction

  task automatic rand_cycle(input int p_valid, input int p_ready, input int p_start_pm);
    logic [4:0] op;
    op = ($urandom_range(0, 9) == 0) ? 5'($urandom) : ops_sup[$urandom_range(0, 7)];
    set_fields(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), rand_imm());
    bus.in_funct7 = 7'($urandom);
    bus.in_valid  = ($urandom_range(0, 99) < p_valid);
    bus.wr_ready  = ($urandom_range(0, 99) < p_ready);
    bus.start     = ($urandom_range(0, 999) < p_start_pm);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.wr_ready = 1'b1;
    set_fields(5'h0, 5'h0, 5'h0, 5'h0, 3'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_wr_en",     32'(bus.wr_en),     32'd0);
    chk("rst_wr_addr",   32'(bus.wr_addr),   32'd0);
    chk("rst_wr_data",   bus.wr_data,        32'h0);
    chk("rst_err_valid", 32'(bus.err_valid), 32'd0);
    chk("rst_err_code",  32'(bus.err_code),  32'd0);
    chk("rst_full",      32'(bus.full),      32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed words
    send(5'b00100, 5'd1, 5'd0, 5'd0, 3'b000, 32'd5);
    chk("addi_wr_en", 32'(bus.wr_en), 32'd1);
    chk("addi_addr",  32'(bus.wr_addr), 32'd0);
    chk("addi_data",  bus.wr_data, 32'h00500093);
    send(5'b01000, 5'd0, 5'd3, 5'd2, 3'b010, 32'd8);
    chk("sw_addr", 32'(bus.wr_addr), 32'd1);
    chk("sw_data", bus.wr_data, 32'h0021A423);
    send(5'b11011, 5'd1, 5'd0, 5'd0, 3'b000, 32'hFFFFFFFC);
    chk("jal_addr", 32'(bus.wr_addr), 32'd2);
    chk("jal_data", bus.wr_data, 32'hFFDFF0EF);

    send(5'b00100, 5'd1, 5'd0, 5'd0, 3'b000, 32'd2048);
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    chk("range_err_valid", 32'(bus.err_valid), 32'd1);
    chk("range_err_code",  32'(bus.err_code),  32'd1);
    chk("range_no_write",  32'(bus.wr_en),     32'd0);
    chk("range_addr",      32'(bus.wr_addr),   32'd3);
`else
    chk("trunc_err_valid", 32'(bus.err_valid), 32'd0);
    chk("trunc_data",      bus.wr_data,        32'h80000093);
    chk("trunc_addr",      32'(bus.wr_addr),   32'd3);
`endif
    send(5'b11000, 5'd0, 5'd0, 5'd0, 3'b000, 32'd3);
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    chk("misalign_err_valid", 32'(bus.err_valid), 32'd1);
    chk("misalign_err_code",  32'(bus.err_code),  32'd2);
`else
    chk("beq_trunc_data", bus.wr_data, 32'h00000163);
`endif
    send(5'b11111, 5'd0, 5'd0, 5'd0, 3'b000, 32'd0);
    chk("unsup_err_valid", 32'(bus.err_valid), 32'd1);
    chk("unsup_err_code",  32'(bus.err_code),  32'd3);
    chk("unsup_no_write",  32'(bus.wr_en),     32'd0);

    // Back-pressure: pending word held, next bundle waits, accepted on release
    bus.wr_ready = 1'b0;
    send(5'b00100, 5'd1, 5'd0, 5'd0, 3'b000, 32'd5);
    set_fields(5'b01000, 5'd0, 5'd3, 5'd2, 3'b010, 32'd8);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_wr_en",    32'(bus.wr_en),    32'd1);
      chk("stall_data",     bus.wr_data,       32'h00500093);
    end
    bus.wr_ready = 1'b1;
    #1;
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("release_next_wr_en", 32'(bus.wr_en), 32'd1);
    chk("release_next_data",  bus.wr_data,    32'h0021A423);

    // Reset while a write is stalled
    bus.wr_ready = 1'b0;
    send(5'b00100, 5'd1, 5'd0, 5'd0, 3'b000, 32'd5);
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_en", 32'(bus.wr_en),   32'd0);
    chk("midrst_addr",  32'(bus.wr_addr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.wr_ready = 1'b1;
    send(5'b01101, 5'd5, 5'd0, 5'd0, 3'b000, 32'h12345000);
    chk("lui_addr", 32'(bus.wr_addr), 32'd0);
    chk("lui_data", bus.wr_data, 32'h123452B7);

    // Random traffic with occasional restarts
    repeat (800) rand_cycle(60, 70, 20);

    // Fill the whole memory without restarts, then restart
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (1200) rand_cycle(85, 85, 0);
    bus.in_valid = 1'b0;
    bus.wr_ready = 1'b1;
    @(posedge clk); #1;
    chk("filled_full",     32'(bus.full),     32'd1);
    chk("filled_in_ready", 32'(bus.in_ready), 32'd0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    #1;
    chk("restart_addr",     32'(bus.wr_addr),  32'd0);
    chk("restart_full",     32'(bus.full),     32'd0);
    chk("restart_wr_en",    32'(bus.wr_en),    32'd0);
    chk("restart_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
